// File: rtl/axi4_pkg.sv
// AXI4 field widths shared by the DMA engines.
// Latency: n/a (constants only).
// Backpressure: n/a.
package axi4_pkg;

  localparam int LEN_BITS   = 8;
  localparam int SIZE_BITS  = 3;
  localparam int BURST_BITS = 2;
  localparam int RESP_BITS  = 2;

endpackage

// File: rtl/dmac_pkg.sv
// DMA controller shared types: per-burst bookkeeping record and response codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmac_pkg;

  // One entry per accepted read burst, retired on its rlast beat.
  typedef struct packed {
    logic [axi4_pkg::LEN_BITS-1:0] len;   // beats minus one
    logic                          last;  // final burst of the transfer
  } rd_burst_info_t;

  localparam logic [axi4_pkg::RESP_BITS-1:0] RRESP_OKAY = 2'b00;

endpackage

// File: rtl/dmac_burst_fifo.sv
// Small synchronous FIFO holding read-burst bookkeeping records.
// Latency: a pushed entry is visible on head the cycle after the push.
// Backpressure: push is ignored when full, pop is ignored when empty.
//
// Ports: clk/rst (sync, active-high), push/push_dat, pop, full, empty,
//        head (oldest entry, valid while !empty). DEPTH must be a power of two.
module dmac_burst_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/dmac_read_initiator.sv
// AXI4 read master: issues scheduler bursts on AR (up to MAX_OUTSTANDING in flight), streams R beats out.
// Latency: request accept -> arvalid next cycle; R handshake -> data_out_valid next cycle.
// Backpressure: rready drops while data_out is held; rd_req_ready drops on AR stall or outstanding limit.
//
// Ports: clk, rst (sync, active-high); rd_req_* burst request (valid/ready);
//        m_axi_ar* / m_axi_r* AXI4 read channels; data_out_* registered output
//        stream; rd_err sticky error; rd_done pulse after final transfer beat leaves.
// Optional: DMAC_RD_RESP_CHECK_EN enables rresp and burst-length checking on rd_err.
module dmac_read_initiator
  import axi4_pkg::*, dmac_pkg::*;
#(
  parameter int ADDR_WD         = 32,
  parameter int DATA_WD         = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WD-1:0]    rd_req_addr,
  input  logic [BURST_BITS-1:0] rd_req_burst,
  input  logic [LEN_BITS-1:0]   rd_req_len,
  input  logic [SIZE_BITS-1:0]  rd_req_size,
  input  logic                  rd_req_last,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WD-1:0]    m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WD-1:0]    m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [DATA_WD-1:0]    data_out,
  output logic                  data_out_last,
  output logic                  rd_err,
  output logic                  rd_done
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  logic [OW-1:0]  outstanding;
  rd_burst_info_t fifo_head;
  rd_burst_info_t fifo_push_dat;
  logic           fifo_full;
  logic           fifo_empty;
  logic           req_acc;
  logic           r_hs;
  logic           r_last_hs;
  logic           out_hs;

  assign rd_req_ready = (!m_axi_arvalid || m_axi_arready) &&
                        (outstanding < OW'(MAX_OUTSTANDING));
  assign m_axi_rready = (outstanding != '0) && (!data_out_valid || data_out_ready);

  assign req_acc   = rd_req_valid && rd_req_ready;
  assign r_hs      = m_axi_rvalid && m_axi_rready;
  assign r_last_hs = r_hs && m_axi_rlast;
  assign out_hs    = data_out_valid && data_out_ready;

  assign fifo_push_dat = '{len: rd_req_len, last: rd_req_last};

  // One entry per burst in flight; head describes the burst currently returning on R.
  dmac_burst_fifo #(
    .WIDTH ($bits(rd_burst_info_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_burst_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (req_acc),
    .push_dat (fifo_push_dat),
    .pop      (r_last_hs),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  // AR channel: a same-cycle accept overrides the release so arvalid stays high with the new payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
    end else if (req_acc) begin
      m_axi_arvalid <= 1'b1;
      m_axi_araddr  <= rd_req_addr;
      m_axi_arlen   <= rd_req_len;
      m_axi_arsize  <= rd_req_size;
      m_axi_arburst <= rd_req_burst;
    end else if (m_axi_arready) begin
      m_axi_arvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({req_acc, r_last_hs})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Output register; rready guarantees a held beat is never overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_valid <= 1'b0;
      data_out       <= '0;
      data_out_last  <= 1'b0;
      rd_done        <= 1'b0;
    end else begin
      rd_done <= out_hs && data_out_last;
      if (r_hs) begin
        data_out_valid <= 1'b1;
        data_out       <= m_axi_rdata;
        data_out_last  <= m_axi_rlast && fifo_head.last;
      end else if (data_out_ready) begin
        data_out_valid <= 1'b0;
        data_out_last  <= 1'b0;
      end
    end
  end

  logic unused_fifo_flags;
  assign unused_fifo_flags = ^{fifo_full, fifo_empty};

`ifdef DMAC_RD_RESP_CHECK_EN
  // Remaining beats of the current burst; the first beat takes its count from the FIFO head.
  logic [LEN_BITS-1:0] beat_cnt;
  logic                in_burst;
  logic [LEN_BITS-1:0] cur_cnt;

  assign cur_cnt = in_burst ? beat_cnt : fifo_head.len;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      in_burst <= 1'b0;
      rd_err   <= 1'b0;
    end else if (r_hs) begin
      if ((m_axi_rresp != RRESP_OKAY) ||
          (m_axi_rlast && (cur_cnt != '0)) ||
          (!m_axi_rlast && (cur_cnt == '0))) begin
        rd_err <= 1'b1;
      end
      in_burst <= !m_axi_rlast;
      beat_cnt <= cur_cnt - LEN_BITS'(1);
    end
  end
`else
  logic unused_chk;
  assign unused_chk = ^{m_axi_rresp, fifo_head.len};
  assign rd_err     = 1'b0;
`endif

endmodule

// File: tb/tb_dmac_read_initiator.sv
// Self-checking bench for dmac_read_initiator: directed scenarios plus randomized traffic,
// scored against a transaction-level model (request/AR/burst queues, one-deep output scoreboard).
// Define DMAC_RD_RESP_CHECK_EN on both bench and RTL to exercise the error-checking build.
module tb_dmac_read_initiator;
  import axi4_pkg::*;

  localparam int ADDR_WD = 32;
  localparam int DATA_WD = 32;
  localparam int MAX_OUT = 4;
`ifdef DMAC_RD_RESP_CHECK_EN
  localparam logic ERR_CHK = 1'b1;
`else
  localparam logic ERR_CHK = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WD-1:0]    rd_req_addr;
  logic [BURST_BITS-1:0] rd_req_burst;
  logic [LEN_BITS-1:0]   rd_req_len;
  logic [SIZE_BITS-1:0]  rd_req_size;
  logic                  rd_req_last;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [ADDR_WD-1:0]    m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [DATA_WD-1:0]    m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic [DATA_WD-1:0]    data_out;
  logic                  data_out_last;
  logic                  rd_err;
  logic                  rd_done;

  always #5 clk = ~clk;

  dmac_read_initiator #(
    .ADDR_WD (ADDR_WD), .DATA_WD (DATA_WD), .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk (clk), .rst (rst),
    .rd_req_valid (rd_req_valid), .rd_req_ready (rd_req_ready),
    .rd_req_addr (rd_req_addr), .rd_req_burst (rd_req_burst),
    .rd_req_len (rd_req_len), .rd_req_size (rd_req_size), .rd_req_last (rd_req_last),
    .m_axi_arvalid (m_axi_arvalid), .m_axi_arready (m_axi_arready),
    .m_axi_araddr (m_axi_araddr), .m_axi_arlen (m_axi_arlen),
    .m_axi_arsize (m_axi_arsize), .m_axi_arburst (m_axi_arburst),
    .m_axi_rvalid (m_axi_rvalid), .m_axi_rready (m_axi_rready),
    .m_axi_rdata (m_axi_rdata), .m_axi_rresp (m_axi_rresp), .m_axi_rlast (m_axi_rlast),
    .data_out_valid (data_out_valid), .data_out_ready (data_out_ready),
    .data_out (data_out), .data_out_last (data_out_last),
    .rd_err (rd_err), .rd_done (rd_done)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        last;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  // Model state
  req_t        todo_q[$];   // requests still to be offered
  req_t        arq[$];      // accepted, AR handshake pending
  req_t        bq[$];       // accepted, burst not yet finished
  logic [7:0]  sq[$];       // slave: bursts seen on AR, data still owed
  beat_t       sb[$];       // content expected in the output register
  logic [31:0] out_log[$];
  int          out_cyc[$];
  int          outst, beat_idx;
  logic        exp_done, exp_err;

  // Slave state and stimulus policy
  logic        s_vld, req_taken;
  int          s_beat, ar_hold;
  int          req_pct, ar_pct, r_pct, rdy_pct;
  bit          rdy_toggle, fixed_data;
  int          err_beat, early_last;

  int n_chk, n_fail, cyc, done_cnt, acc_cnt, rhs_cnt, last_acc_cyc, first_rlast_cyc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check ready terms, advance model.
  task automatic step();
    bit    acc, arhs, ohs, rhs, exp_qrdy, exp_rrdy;
    beat_t b;
    chk("arvalid", m_axi_arvalid, arq.size() != 0);
    if (arq.size() != 0) begin
      chk("araddr", m_axi_araddr, arq[0].addr);
      chk("arlen", m_axi_arlen, arq[0].len);
      chk("arsize", m_axi_arsize, arq[0].size);
      chk("arburst", m_axi_arburst, arq[0].burst);
    end
    chk("dout_valid", data_out_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      chk("dout_data", data_out, sb[0].data);
      chk("dout_last", data_out_last, sb[0].last);
    end
    chk("rd_done", rd_done, exp_done);
    chk("rd_err", rd_err, exp_err);
    if (rd_done === 1'b1) done_cnt++;

    if (req_taken) begin
      rd_req_valid = 1'b0;
      req_taken    = 1'b0;
    end
    if (!rd_req_valid && todo_q.size() != 0 && roll(req_pct)) begin
      rd_req_valid = 1'b1;
      rd_req_addr  = todo_q[0].addr;
      rd_req_len   = todo_q[0].len;
      rd_req_size  = todo_q[0].size;
      rd_req_burst = todo_q[0].burst;
      rd_req_last  = todo_q[0].last;
    end
    if (ar_hold > 0) begin
      m_axi_arready = 1'b0;
      ar_hold--;
    end else begin
      m_axi_arready = roll(ar_pct);
    end
    if (!s_vld && sq.size() != 0 && roll(r_pct)) begin
      s_vld       = 1'b1;
      m_axi_rdata = fixed_data ? 32'hA0 + s_beat : $urandom;
      m_axi_rlast = (s_beat == int'(sq[0])) || (s_beat == early_last);
      m_axi_rresp = (s_beat == err_beat) ? 2'b10 : 2'b00;
    end
    m_axi_rvalid   = s_vld;
    data_out_ready = rdy_toggle ? !data_out_ready : roll(rdy_pct);

    #1;
    exp_qrdy = (arq.size() == 0 || m_axi_arready) && (outst < MAX_OUT);
    exp_rrdy = (outst != 0) && (sb.size() == 0 || data_out_ready);
    chk("rd_req_ready", rd_req_ready, exp_qrdy);
    chk("rready", m_axi_rready, exp_rrdy);

    arhs = (arq.size() != 0) && m_axi_arready;
    acc  = rd_req_valid && exp_qrdy;
    ohs  = (sb.size() != 0) && data_out_ready;
    rhs  = m_axi_rvalid && exp_rrdy;
    if (arhs) begin
      sq.push_back(arq[0].len);
      arq.pop_front();
    end
    if (acc) begin
      arq.push_back(todo_q[0]);
      bq.push_back(todo_q[0]);
      todo_q.pop_front();
      outst++;
      acc_cnt++;
      last_acc_cyc = cyc;
      req_taken    = 1'b1;
    end
    exp_done = 1'b0;
    if (ohs) begin
      exp_done = sb[0].last;
      out_log.push_back(sb[0].data);
      out_cyc.push_back(cyc);
      sb.pop_front();
    end
    if (rhs) begin
      b.data = m_axi_rdata;
      b.last = m_axi_rlast && bq[0].last;
      sb.push_back(b);
      rhs_cnt++;
      if (ERR_CHK && (m_axi_rresp != 2'b00 || (m_axi_rlast != (beat_idx == int'(bq[0].len)))))
        exp_err = 1'b1;
      beat_idx++;
      s_vld = 1'b0;
      s_beat++;
      if (m_axi_rlast) begin
        bq.pop_front();
        sq.pop_front();
        outst--;
        beat_idx = 0;
        s_beat   = 0;
        if (first_rlast_cyc < 0) first_rlast_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_req_len = '0; rd_req_size = '0;
    rd_req_burst = '0; rd_req_last = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; data_out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    todo_q.delete(); arq.delete(); bq.delete(); sq.delete(); sb.delete();
    outst = 0; beat_idx = 0; exp_done = 1'b0; exp_err = 1'b0;
    s_vld = 1'b0; s_beat = 0; req_taken = 1'b0; ar_hold = 0;
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
    chk("rst_arsize", m_axi_arsize, 0);
    chk("rst_arburst", m_axi_arburst, 0);
    chk("rst_dout_valid", data_out_valid, 1'b0);
    chk("rst_dout", data_out, 0);
    chk("rst_dout_last", data_out_last, 1'b0);
    chk("rst_rd_err", rd_err, 1'b0);
    chk("rst_rd_done", rd_done, 1'b0);
    chk("rst_req_ready", rd_req_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    // A leftover beat from before reset must not be taken.
    m_axi_rvalid = 1'b1;
    #1;
    chk("rst_stale_rready", m_axi_rready, 1'b0);
    m_axi_rvalid = 1'b0;
  endtask

  task automatic run_idle(input string tag);
    int n;
    n = 0;
    while ((todo_q.size() != 0 || arq.size() != 0 || outst != 0 || sb.size() != 0) && n < 400) begin
      step();
      n++;
    end
    chk(tag, n < 400, 1'b1);
    repeat (2) step();
  endtask

  task automatic set_policy(input int rq, input int ar, input int r, input int rdy);
    req_pct = rq; ar_pct = ar; r_pct = r; rdy_pct = rdy;
  endtask

  task automatic add_req(input logic [31:0] addr, input logic [7:0] len, input logic last);
    req_t r;
    r.addr = addr; r.len = len; r.size = 3'd2; r.burst = 2'b01; r.last = last;
    todo_q.push_back(r);
  endtask

  task automatic clear_logs();
    out_log.delete(); out_cyc.delete();
    done_cnt = 0; acc_cnt = 0; rhs_cnt = 0; first_rlast_cyc = -1; last_acc_cyc = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_chk = 0; n_fail = 0; cyc = 0;
    rdy_toggle = 0; fixed_data = 1; err_beat = -1; early_last = -1;
    clear_logs();
    do_reset();

    // Single transfer: 4 beats, last only on the final one, one done pulse, back-to-back beats.
    set_policy(100, 100, 100, 100);
    add_req(32'h100, 8'd3, 1'b1);
    run_idle("T1_idle");
    chk("T1_beats", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) chk("T1_data", out_log[i], 32'hA0 + i);
    chk("T1_done_pulses", done_cnt, 1);
    if (out_cyc.size() == 4) chk("T1_rate", out_cyc[3] - out_cyc[0], 3);

    // Outstanding limit: 4 accepted, the 5th only after the first rlast has updated the count.
    do_reset(); clear_logs();
    set_policy(100, 100, 0, 100);
    for (int i = 0; i < 5; i++) add_req(32'h1000 + 32'(i * 64), 8'd0, i == 4);
    repeat (8) step();
    chk("T2_accepted", acc_cnt, 4);
    chk("T2_req_ready_low", rd_req_ready, 1'b0);
    r_pct = 100;
    run_idle("T2_idle");
    chk("T2_all_accepted", acc_cnt, 5);
    // Ready is derived from the registered count, so it rises the cycle after that rlast.
    chk("T2_accept_after_rlast", last_acc_cyc, first_rlast_cyc + 1);

    // Backpressure: output ready toggling during an 8-beat burst.
    do_reset(); clear_logs();
    set_policy(100, 100, 100, 100);
    rdy_toggle = 1;
    add_req(32'h2000, 8'd7, 1'b1);
    run_idle("T3_idle");
    rdy_toggle = 0;
    chk("T3_beats", out_log.size(), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) chk("T3_data", out_log[i], 32'hA0 + i);
    chk("T3_done_pulses", done_cnt, 1);

    // AR stall: arready low while the first AR waits; the second request must wait too.
    do_reset(); clear_logs();
    set_policy(100, 100, 100, 100);
    ar_hold = 4;
    add_req(32'h3000, 8'd1, 1'b0);
    add_req(32'h3040, 8'd2, 1'b1);
    repeat (4) step();
    chk("T4_one_accepted", acc_cnt, 1);
    chk("T4_arvalid_held", m_axi_arvalid, 1'b1);
    run_idle("T4_idle");
    chk("T4_beats", out_log.size(), 5);

    // Error response on beat 2.
    do_reset(); clear_logs();
    set_policy(100, 100, 100, 100);
    err_beat = 2;
    add_req(32'h4000, 8'd3, 1'b1);
    run_idle("T5_idle");
    chk("T5_resp_err", rd_err, ERR_CHK);
    err_beat = -1;
    // Early rlast on beat 1 of a 4-beat burst.
    do_reset(); clear_logs();
    early_last = 1;
    add_req(32'h4100, 8'd3, 1'b1);
    run_idle("T5b_idle");
    chk("T5_len_err", rd_err, ERR_CHK);
    chk("T5b_beats", out_log.size(), 2);
    early_last = -1;

    // Reset in the middle of a burst, then a clean transfer.
    do_reset(); clear_logs();
    set_policy(100, 100, 100, 100);
    add_req(32'h5000, 8'd3, 1'b1);
    n = 0;
    while (rhs_cnt < 2 && n < 50) begin
      step();
      n++;
    end
    chk("T6_two_beats", rhs_cnt, 2);
    do_reset(); clear_logs();
    add_req(32'h5100, 8'd3, 1'b1);
    run_idle("T6_idle");
    chk("T6_beats", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) chk("T6_data", out_log[i], 32'hA0 + i);
    chk("T6_done_pulses", done_cnt, 1);

    // Random traffic.
    do_reset(); clear_logs();
    fixed_data = 0;
    for (int phase = 0; phase < 4; phase++) begin
      set_policy($urandom_range(100, 30), $urandom_range(100, 20),
                 $urandom_range(100, 20), $urandom_range(100, 20));
      for (int k = 0; k < 200; k++) begin
        if (todo_q.size() < 3)
          add_req($urandom, 8'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
        step();
      end
    end
    set_policy(100, 100, 100, 100);
    run_idle("T7_idle");
    chk("T7_all_beats_out", out_log.size(), rhs_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
